xls_add_tree_pipe: RTL and testbench
====================================

XLS_ADD_TREE_PIPE -- requirements
Module: xls_add_tree_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result bit width (1..64).
REQ-002 SHALL have parameter NUM_IN, default 3, operand count (2..16).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand vector valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  operands; operand i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_data  output  WIDTH  sum of operands.
REQ-011 SHALL have port out_ovf  output  1  carry lost in any addition; present only with XLS_ADD_TREE_OVF_EN.

Function
REQ-012 SHALL compute out_data = sum of all NUM_IN operands modulo 2^WIDTH (unsigned wrap-around).
REQ-013 SHALL be organised as an input register stage followed by D = ceil(log2(NUM_IN)) registered adder levels; latency L = 1 + D cycles from accepted input to out_valid with no stall (NUM_IN=3: L=3).
REQ-014 Each adder level SHALL pair adjacent operands (0+1, 2+3, ...); an unpaired last operand SHALL pass through registered unchanged.
REQ-015 Each stage k SHALL hold a valid bit; stage k loads when !valid[k] or stage k+1 loads (last stage: when !out_valid or out_ready).
REQ-016 in_ready SHALL equal the load enable of the input stage; a transfer occurs only when in_valid && in_ready.
REQ-017 Bubbles SHALL be collapsed: an empty stage accepts data even while downstream stalls.
REQ-018 With out_ready held high, throughput SHALL be one result per cycle.
REQ-019 While out_valid && !out_ready, out_data (and out_ovf) SHALL remain stable.
REQ-020 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-021 in_ready SHALL depend combinationally only on out_ready and internal valid bits, never on in_valid.

Reset
REQ-022 On rst_n low, all valid bits SHALL clear asynchronously: out_valid=0, out_ovf=0, in_ready=1 from reset deassertion.
REQ-023 Data registers SHALL NOT require reset; out_data after reset is don't-care while out_valid=0.
REQ-024 Reset mid-operation SHALL discard all in-flight vectors; first post-reset result corresponds to first post-reset accepted input.

Configuration
REQ-025 Macro XLS_ADD_TREE_OVF_EN defined: each level SHALL carry a sticky overflow bit OR-ing all carry-outs of that vector's additions; out_ovf reports it aligned with out_data.
REQ-026 Macro undefined: out_ovf port and overflow logic SHALL be absent; data path otherwise identical.

Structure
REQ-027 Package xls_add_tree_pkg SHALL hold function clog2-based level count, per-level operand count function, and MAX_NUM_IN = 16 constant.
REQ-028 Sub-module xls_add_tree_level (one registered adder level with valid/ready, parameters WIDTH, N_IN) SHALL be instantiated D times via generate.

Verification
REQ-029 NUM_IN=3, WIDTH=32, out_ready=1: operands 1,2,3 -> out_data=6, out_valid exactly 3 cycles after acceptance, out_ovf=0.
REQ-030 Wrap: operands 0xFFFFFFFF,1,0 -> out_data=0, out_ovf=1 (macro on); out_ovf port absent (macro off).
REQ-031 Stream 10 vectors back-to-back, out_ready=0 for cycles 4-7: all 10 sums in order, out_data stable while stalled, in_ready low once all stages full.
REQ-032 Reset pulse with 2 vectors in flight: out_valid=0 immediately, no stale result after reset; next vector 5,5,5 -> 15.
REQ-033 NUM_IN=8, WIDTH=8: operands 1..8 -> 36 after L=4 cycles; operands all 0x20 -> 0x00, out_ovf=1.
REQ-034 NUM_IN=2 and NUM_IN=5 random streaming with random out_ready vs. golden modular-sum model: zero mismatches over 10k vectors.

Source files
------------

// File: rtl/xls_add_tree_pkg.sv
// rtl/xls_add_tree_pkg.sv - shared constants and sizing functions for the pipelined adder tree
//
// Purpose: holds the operand-count limit and the constant functions that size
// the tree: how many registered adder levels a given operand count needs, and
// how many operands enter each level.
// Ports: none (package).
// Optional feature macro used by the files importing this package: XLS_ADD_TREE_OVF_EN.

package xls_add_tree_pkg;

    localparam int MAX_NUM_IN = 16;

    // Number of registered adder levels needed to reduce n operands to one.
    function automatic int num_levels(input int n);
        return $clog2(n);
    endfunction

    // Operand count entering adder level k (k = 0 is the raw operand vector).
    // Each level pairs neighbours, so the count halves rounding up.
    function automatic int level_width(input int n, input int k);
        int c;
        c = n;
        for (int i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

endpackage

// File: rtl/xls_add_tree_level.sv
// rtl/xls_add_tree_level.sv - one registered adder level of the tree with valid/ready
//
// Purpose: adds adjacent operand pairs (0+1, 2+3, ...) and registers the
// results; an unpaired last operand is registered unchanged. The stage holds a
// valid bit and loads whenever it is empty or its consumer takes its contents,
// so an empty stage keeps accepting while downstream stalls.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (valid/ovf only)
//   in_valid/in_ready  upstream handshake; in_ready is this stage's load enable
//   in_data            N_IN operands, operand i at [i*WIDTH +: WIDTH]
//   in_ovf             sticky overflow arriving with the operands (macro on)
//   out_valid/out_ready downstream handshake
//   out_data           N_OUT = ceil(N_IN/2) results
//   out_ovf            sticky overflow aligned with out_data (macro on)
// Macro: XLS_ADD_TREE_OVF_EN adds the overflow ports and carry tracking.

module xls_add_tree_level
    import xls_add_tree_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
`ifdef XLS_ADD_TREE_OVF_EN
    input  logic                   in_ovf,
    output logic                   out_ovf,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data
);

    logic                   valid_q, valid_d;
    logic [N_OUT*WIDTH-1:0] data_q, data_d;
    logic [N_OUT*WIDTH-1:0] comb_data;
    logic                   load;

`ifdef XLS_ADD_TREE_OVF_EN
    logic                   ovf_q, ovf_d;
    logic [N_OUT-1:0]       carry_vec;
`endif

    assign load      = !valid_q || out_ready;
    assign in_ready  = load;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    genvar j;
    generate
        for (j = 0; j < N_OUT; j++) begin : gen_pair
            if (2 * j + 1 < N_IN) begin : g_add
`ifdef XLS_ADD_TREE_OVF_EN
                logic [WIDTH:0] sum;
                assign sum = {1'b0, in_data[2*j*WIDTH +: WIDTH]}
                           + {1'b0, in_data[(2*j+1)*WIDTH +: WIDTH]};
                assign comb_data[j*WIDTH +: WIDTH] = sum[WIDTH-1:0];
                assign carry_vec[j] = sum[WIDTH];
`else
                assign comb_data[j*WIDTH +: WIDTH] = in_data[2*j*WIDTH +: WIDTH]
                                                   + in_data[(2*j+1)*WIDTH +: WIDTH];
`endif
            end else begin : g_pass
                assign comb_data[j*WIDTH +: WIDTH] = in_data[2*j*WIDTH +: WIDTH];
`ifdef XLS_ADD_TREE_OVF_EN
                assign carry_vec[j] = 1'b0;
`endif
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef XLS_ADD_TREE_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (load) begin
            valid_d = in_valid;
            // Keep the old data when loading a bubble; it is invisible anyway.
            if (in_valid) begin
                data_d = comb_data;
            end
`ifdef XLS_ADD_TREE_OVF_EN
            ovf_d = in_valid && (in_ovf || (|carry_vec));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
`ifdef XLS_ADD_TREE_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
`ifdef XLS_ADD_TREE_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Data path needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

`ifdef XLS_ADD_TREE_OVF_EN
    assign out_ovf = ovf_q;
`endif

endmodule

// File: rtl/xls_add_tree_pipe.sv
// rtl/xls_add_tree_pipe.sv - pipelined modular adder tree with elastic valid/ready stages
//
// Purpose: sums NUM_IN unsigned WIDTH-bit operands modulo 2^WIDTH. An input
// register stage is followed by ceil(log2(NUM_IN)) registered adder levels,
// giving a latency of 1 + levels cycles with one result per cycle when the
// consumer never stalls. Every stage has its own valid bit so bubbles collapse.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand vector handshake; in_ready never looks at in_valid
//   in_data             operands, operand i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready result handshake
//   out_data            modular sum
//   out_ovf             a carry was lost in some addition (macro on only)
// Macro: XLS_ADD_TREE_OVF_EN enables the out_ovf port and overflow tracking.

module xls_add_tree_pipe
    import xls_add_tree_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
`ifdef XLS_ADD_TREE_OVF_EN
    ,
    output logic                    out_ovf
`endif
);

    localparam int D = num_levels(NUM_IN);

    logic                    in_valid_q, in_valid_d;
    logic [NUM_IN*WIDTH-1:0] in_data_q, in_data_d;
    logic                    in_load;

    // Per-level handshake signals, index = adder level.
    logic [D-1:0]            lvl_ready;
    logic [D-1:0]            lvl_valid;
`ifdef XLS_ADD_TREE_OVF_EN
    logic [D-1:0]            lvl_ovf;
`endif

    // Input stage: plain elastic register in front of the tree.
    assign in_load  = !in_valid_q || lvl_ready[0];
    assign in_ready = in_load;

    always_comb begin
        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        if (in_load) begin
            in_valid_d = in_valid;
            if (in_valid) begin
                in_data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
        end else begin
            in_valid_q <= in_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        in_data_q <= in_data_d;
    end

    genvar k;
    generate
        for (k = 0; k < D; k++) begin : gen_lvl
            localparam int NI = level_width(NUM_IN, k);
            localparam int NO = level_width(NUM_IN, k + 1);

            logic               src_valid;
            logic [NI*WIDTH-1:0] src_data;
            logic               dst_ready;
            logic [NO*WIDTH-1:0] dat;
`ifdef XLS_ADD_TREE_OVF_EN
            logic               src_ovf;
`endif

            if (k == 0) begin : g_first
                assign src_valid = in_valid_q;
                assign src_data  = in_data_q;
`ifdef XLS_ADD_TREE_OVF_EN
                assign src_ovf   = 1'b0;
`endif
            end else begin : g_next
                assign src_valid = lvl_valid[k-1];
                assign src_data  = gen_lvl[k-1].dat;
`ifdef XLS_ADD_TREE_OVF_EN
                assign src_ovf   = lvl_ovf[k-1];
`endif
            end

            if (k == D - 1) begin : g_last
                assign dst_ready = out_ready;
            end else begin : g_inner
                assign dst_ready = lvl_ready[k+1];
            end

            xls_add_tree_level #(
                .WIDTH (WIDTH),
                .N_IN  (NI)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (src_valid),
                .in_ready  (lvl_ready[k]),
                .in_data   (src_data),
`ifdef XLS_ADD_TREE_OVF_EN
                .in_ovf    (src_ovf),
                .out_ovf   (lvl_ovf[k]),
`endif
                .out_valid (lvl_valid[k]),
                .out_ready (dst_ready),
                .out_data  (dat)
            );
        end
    endgenerate

    assign out_valid = lvl_valid[D-1];
    assign out_data  = gen_lvl[D-1].dat;
`ifdef XLS_ADD_TREE_OVF_EN
    assign out_ovf   = lvl_ovf[D-1];
`endif

endmodule

// File: tb/tb_xls_add_tree_pipe.sv
// tb/tb_xls_add_tree_pipe.sv - self-checking bench for xls_add_tree_pipe

module tb_xls_add_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    // A: NUM_IN=3 WIDTH=32
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [95:0] a_in_data;
    logic [31:0] a_out_data;
    // B: NUM_IN=8 WIDTH=8
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data;
    logic [7:0]  b_out_data;
    // C: NUM_IN=2 WIDTH=32
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [63:0] c_in_data;
    logic [31:0] c_out_data;
    // E: NUM_IN=5 WIDTH=16
    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready;
    logic [79:0] e_in_data;
    logic [15:0] e_out_data;
`ifdef XLS_ADD_TREE_OVF_EN
    logic        a_ovf, b_ovf, c_ovf, e_ovf;
`endif

    xls_add_tree_pipe #(.WIDTH(32), .NUM_IN(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data)
`ifdef XLS_ADD_TREE_OVF_EN
        , .out_ovf(a_ovf)
`endif
    );
    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data)
`ifdef XLS_ADD_TREE_OVF_EN
        , .out_ovf(b_ovf)
`endif
    );
    xls_add_tree_pipe #(.WIDTH(32), .NUM_IN(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data)
`ifdef XLS_ADD_TREE_OVF_EN
        , .out_ovf(c_ovf)
`endif
    );
    xls_add_tree_pipe #(.WIDTH(16), .NUM_IN(5)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_data(e_in_data), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_data(e_out_data)
`ifdef XLS_ADD_TREE_OVF_EN
        , .out_ovf(e_ovf)
`endif
    );

    // Reference: exact (unwrapped) sum of n operands of w bits each.
    // Modular result is the low w bits; a carry was lost iff anything is above them.
    function automatic logic [71:0] full_sum(input logic [1023:0] v, input int n, input int w);
        logic [71:0]   s;
        logic [1023:0] t;
        s = '0;
        t = v;
        for (int i = 0; i < n; i++) begin
            s = s + 72'(t[63:0] & ((64'd1 << w) - 64'd1));
            t = t >> w;
        end
        return s;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); else n_pass++;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); else n_pass++;
        n_total++; if ({b_out_valid, c_out_valid, e_out_valid} !== 3'b000)
            $display("FAIL reset_other_out_valid: got %b want 000", {b_out_valid, c_out_valid, e_out_valid}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", a_in_ready); else n_pass++;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b want 0", a_out_valid); else n_pass++;
`ifdef XLS_ADD_TREE_OVF_EN
        n_total++; if (a_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", a_ovf); else n_pass++;
`endif
    endtask

    // Send one vector to A with out_ready high and check latency, sum and overflow.
    task automatic test_single_a(input string name, input logic [95:0] vec,
                                 input logic [31:0] want, input logic want_ovf);
        int cyc;
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        a_in_data   = vec;
        a_in_valid  = 1'b1;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b want 1", name, a_in_ready); else n_pass++;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) a_in_valid = 1'b0;
        end while (!a_out_valid && cyc < 20);
        n_total++; if (cyc !== 3) $display("FAIL %s_latency: got %0d want 3", name, cyc); else n_pass++;
        n_total++; if (a_out_data !== want) $display("FAIL %s_data: got %h want %h", name, a_out_data, want); else n_pass++;
`ifdef XLS_ADD_TREE_OVF_EN
        n_total++; if (a_ovf !== want_ovf) $display("FAIL %s_ovf: got %b want %b", name, a_ovf, want_ovf); else n_pass++;
`else
        if (want_ovf === 1'bx) $display("unexpected x flag");
`endif
        @(posedge clk);
        #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL %s_no_dup: got %b want 0", name, a_out_valid); else n_pass++;
    endtask

    task automatic test_basic;
        test_single_a("basic", {32'd3, 32'd2, 32'd1}, 32'd6, 1'b0);
    endtask

    task automatic test_wrap;
        test_single_a("wrap", {32'd0, 32'd1, 32'hFFFF_FFFF}, 32'd0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        logic [95:0] vecs[10];
        logic [71:0] s;
        logic [31:0] prev_data;
        logic        stalled_prev;
        int          sent, got, cyc;
        for (int i = 0; i < 10; i++) vecs[i] = {$urandom(), $urandom(), $urandom()};
        sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0; prev_data = '0;
        @(posedge clk);
        #1;
        while (got < 10 && cyc < 100) begin
            a_out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 10) begin
                a_in_valid = 1'b1;
                a_in_data  = vecs[sent];
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (stalled_prev) begin
                n_total++; if (a_out_valid !== 1'b1 || a_out_data !== prev_data)
                    $display("FAIL b2b_stall_stable: got v=%b d=%h want v=1 d=%h", a_out_valid, a_out_data, prev_data); else n_pass++;
            end
            if (cyc >= 4 && cyc <= 7) begin
                n_total++; if (a_in_ready !== 1'b0) $display("FAIL b2b_in_ready_full: cycle %0d got %b want 0", cyc, a_in_ready); else n_pass++;
            end
            if (a_in_valid && a_in_ready) begin
                s = full_sum(1024'(vecs[sent]), 3, 32);
                exp_q.push_back(s[31:0]);
                sent++;
            end
            if (a_out_valid && a_out_ready) begin
                n_total++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra_result: got %h want none", a_out_data);
                else if (a_out_data !== exp_q[0]) $display("FAIL b2b_data: got %h want %h", a_out_data, exp_q[0]);
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            stalled_prev = a_out_valid && !a_out_ready;
            prev_data    = a_out_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        n_total++; if (got !== 10) $display("FAIL b2b_count: got %0d want 10", got); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = {32'd7, 32'd8, 32'd9};
        @(posedge clk);
        #1;
        a_in_data   = {32'd10, 32'd11, 32'd12};
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        @(posedge clk);
        #2;
        n_total++; if (a_out_valid !== 1'b1) $display("FAIL rstmid_before: got %b want 1", a_out_valid); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL rstmid_async_clear: got %b want 0", a_out_valid); else n_pass++;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", a_in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_total++; if (a_out_valid !== 1'b0) $display("FAIL rstmid_stale: cycle %0d got %b want 0", i, a_out_valid); else n_pass++;
        end
        @(posedge clk);
        #1;
        a_in_data  = {32'd5, 32'd5, 32'd5};
        a_in_valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) a_in_valid = 1'b0;
        end while (!a_out_valid && cyc < 20);
        n_total++; if (cyc !== 3) $display("FAIL rstmid_latency: got %0d want 3", cyc); else n_pass++;
        n_total++; if (a_out_data !== 32'd15) $display("FAIL rstmid_data: got %0d want 15", a_out_data); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_n8;
        int cyc;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            #1;
            b_out_ready = 1'b1;
            for (int i = 0; i < 8; i++) b_in_data[i*8 +: 8] = (pass == 0) ? 8'(i + 1) : 8'h20;
            b_in_valid = 1'b1;
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == 1) b_in_valid = 1'b0;
            end while (!b_out_valid && cyc < 20);
            n_total++; if (cyc !== 4) $display("FAIL n8_latency_%0d: got %0d want 4", pass, cyc); else n_pass++;
            n_total++; if (b_out_data !== ((pass == 0) ? 8'd36 : 8'h00))
                $display("FAIL n8_data_%0d: got %h want %h", pass, b_out_data, (pass == 0) ? 8'd36 : 8'h00); else n_pass++;
`ifdef XLS_ADD_TREE_OVF_EN
            n_total++; if (b_ovf !== (pass == 1)) $display("FAIL n8_ovf_%0d: got %b want %b", pass, b_ovf, pass == 1); else n_pass++;
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random;
        logic [32:0] c_exp[$];
        logic [16:0] e_exp[$];
        logic [71:0] s;
        logic [31:0] c_prev;
        logic [15:0] e_prev;
        logic        c_stall, e_stall, c_acc, e_acc;
        int          c_sent, e_sent, c_got, e_got, cyc;
        c_sent = 0; e_sent = 0; c_got = 0; e_got = 0; cyc = 0;
        c_stall = 1'b0; e_stall = 1'b0; c_acc = 1'b0; e_acc = 1'b0;
        c_prev = '0; e_prev = '0;
        c_in_valid = 1'b0; e_in_valid = 1'b0;
        while ((c_got < 10000 || e_got < 10000) && cyc < 60000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!c_in_valid || c_acc) begin
                c_in_valid = (c_sent < 10000) && ($urandom_range(0, 3) != 0);
                c_in_data  = {$urandom(), $urandom()};
            end
            if (!e_in_valid || e_acc) begin
                e_in_valid = (e_sent < 10000) && ($urandom_range(0, 3) != 0);
                e_in_data  = {$urandom(), $urandom(), 16'($urandom())};
            end
            c_out_ready = ($urandom_range(0, 3) != 0);
            e_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (c_stall) begin
                n_total++; if (c_out_valid !== 1'b1 || c_out_data !== c_prev)
                    $display("FAIL rnd2_stall_stable: got v=%b d=%h want v=1 d=%h", c_out_valid, c_out_data, c_prev); else n_pass++;
            end
            if (e_stall) begin
                n_total++; if (e_out_valid !== 1'b1 || e_out_data !== e_prev)
                    $display("FAIL rnd5_stall_stable: got v=%b d=%h want v=1 d=%h", e_out_valid, e_out_data, e_prev); else n_pass++;
            end
            c_acc = c_in_valid && c_in_ready;
            e_acc = e_in_valid && e_in_ready;
            if (c_acc) begin
                s = full_sum(1024'(c_in_data), 2, 32);
                c_exp.push_back({|s[71:32], s[31:0]});
                c_sent++;
            end
            if (e_acc) begin
                s = full_sum(1024'(e_in_data), 5, 16);
                e_exp.push_back({|s[71:16], s[15:0]});
                e_sent++;
            end
            if (c_out_valid && c_out_ready) begin
                n_total++;
                if (c_exp.size() == 0) $display("FAIL rnd2_extra: got %h want none", c_out_data);
                else if (c_out_data !== c_exp[0][31:0]) $display("FAIL rnd2_data: got %h want %h", c_out_data, c_exp[0][31:0]);
`ifdef XLS_ADD_TREE_OVF_EN
                else if (c_ovf !== c_exp[0][32]) $display("FAIL rnd2_ovf: got %b want %b", c_ovf, c_exp[0][32]);
`endif
                else n_pass++;
                if (c_exp.size() != 0) void'(c_exp.pop_front());
                c_got++;
            end
            if (e_out_valid && e_out_ready) begin
                n_total++;
                if (e_exp.size() == 0) $display("FAIL rnd5_extra: got %h want none", e_out_data);
                else if (e_out_data !== e_exp[0][15:0]) $display("FAIL rnd5_data: got %h want %h", e_out_data, e_exp[0][15:0]);
`ifdef XLS_ADD_TREE_OVF_EN
                else if (e_ovf !== e_exp[0][16]) $display("FAIL rnd5_ovf: got %b want %b", e_ovf, e_exp[0][16]);
`endif
                else n_pass++;
                if (e_exp.size() != 0) void'(e_exp.pop_front());
                e_got++;
            end
            c_stall = c_out_valid && !c_out_ready;
            e_stall = e_out_valid && !e_out_ready;
            c_prev  = c_out_data;
            e_prev  = e_out_data;
        end
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
        e_in_valid = 1'b0;
        n_total++; if (c_got !== 10000) $display("FAIL rnd2_count: got %0d want 10000", c_got); else n_pass++;
        n_total++; if (e_got !== 10000) $display("FAIL rnd5_count: got %0d want 10000", e_got); else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_data = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b1; e_in_data = '0;
        test_reset;
        test_basic;
        test_wrap;
        test_back_to_back;
        test_reset_mid;
        test_n8;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
